// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: start/busy/done handshake and data bus of the iterative right shifter
interface shift_right_seq_if #(parameter int N = 32, parameter int SW = 5);
  logic          start;
  logic [N-1:0]  A;
  logic [SW-1:0] shamt;
  logic          arith;
  logic [N-1:0]  B;
  logic          busy;
  logic          done;
  modport master (output start, A, shamt, arith, input B, busy, done);
  modport slave  (input start, A, shamt, arith, output B, busy, done);
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: one-bit-per-cycle logical/arithmetic right shifter with start/busy/done handshake
module shift_right_seq #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic            clk,
  input  logic            rst,
  shift_right_seq_if.slave s
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] count_q, count_d;
  logic          fill_q, fill_d;
  // DONE accepts a new request exactly like IDLE, giving back-to-back operation
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    fill_d  = fill_q;
    if (state_q == SHIFT) begin
      data_d  = {fill_q, data_q[N-1:1]};
      count_d = count_q - 1'b1;
      state_d = count_q == SW'(1) ? DONE : SHIFT;
    end else if (s.start) begin
      data_d  = s.A;
      count_d = s.shamt;
      fill_d  = s.arith & s.A[N-1];
      state_d = s.shamt == '0 ? DONE : SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end
  assign s.B    = data_q;
  assign s.busy = state_q == SHIFT;
  assign s.done = state_q == DONE;
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: table-driven, hand-sequenced and randomized checks of shift_right_seq
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  shift_right_seq_if #(.N(32), .SW(5)) bus ();
  shift_right_seq #(.N(32), .SW(5)) dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    int          sh;
    logic        ar;
    logic [31:0] exp_b;
  } vec_t;
  vec_t tbl[6];
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh, input logic ar);
    logic signed [31:0] sa;
    sa = a;
    return ar ? 32'(sa >>> sh) : a >> sh;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic start_op(input logic [31:0] a, input int sh, input logic ar);
    bus.A = a;
    bus.shamt = 5'(sh);
    bus.arith = ar;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  // Called #1 after the accepting edge; walks the shift cycle by cycle up to done.
  task automatic track(input string nm, input int sh, input logic [31:0] e, input bit poke, input bit idle_after);
    for (int k = 0; k <= sh; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (poke && k == 1) begin
        bus.start = 1'b1;
        bus.A = $urandom;
        bus.shamt = 5'($urandom_range(0, 31));
        bus.arith = ~bus.arith;
      end
      if (poke && k == sh - 1) bus.start = 1'b0;
      chk({nm, " busy"}, 32'(bus.busy), 32'(k < sh));
      chk({nm, " done"}, 32'(bus.done), 32'(k == sh));
      if (k == sh) chk({nm, " B"}, bus.B, e);
    end
    if (idle_after) begin
      @(posedge clk);
      #1;
      chk({nm, " done drop"}, 32'(bus.done), 32'd0);
      chk({nm, " B held"}, bus.B, e);
    end
  endtask
  initial begin
    bit seen;
    logic [31:0] a;
    int sh;
    logic ar;
    tbl[0] = '{32'h80000000, 4, 1'b1, 32'hF8000000};
    tbl[1] = '{32'h80000000, 4, 1'b0, 32'h08000000};
    tbl[2] = '{32'h12345678, 0, 1'b0, 32'h12345678};
    tbl[3] = '{32'h12345678, 0, 1'b1, 32'h12345678};
    tbl[4] = '{32'hFFFFFFFF, 31, 1'b0, 32'h00000001};
    tbl[5] = '{32'hFFFFFFFF, 31, 1'b1, 32'hFFFFFFFF};
    bus.start = 1'b0;
    bus.A = '0;
    bus.shamt = '0;
    bus.arith = 1'b0;
    #12;
    chk("reset B", bus.B, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl%0d idle busy", i), 32'(bus.busy), 32'd0);
      start_op(tbl[i].a, tbl[i].sh, tbl[i].ar);
      track($sformatf("tbl%0d", i), tbl[i].sh, tbl[i].exp_b, 1'b0, 1'b1);
    end
    start_op(32'h80000000, 6, 1'b1);
    track("repulse", 6, 32'hFE000000, 1'b1, 1'b1);
    start_op(32'h000000F0, 2, 1'b0);
    track("b2b first", 2, 32'h0000003C, 1'b0, 1'b0);
    start_op(32'h00000100, 8, 1'b0);
    track("b2b second", 8, 32'h00000001, 1'b0, 1'b1);
    start_op(32'h12345678, 10, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst B", bus.B, 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 seen |= bus.done | bus.busy;
    end
    chk("midrst no done", 32'(seen), 32'd0);
    chk("midrst B stays", bus.B, 32'd0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      sh = (i % 8 == 0) ? 0 : int'($urandom_range(0, 31));
      ar = 1'($urandom);
      start_op(a, sh, ar);
      bus.A = $urandom;
      bus.shamt = 5'($urandom);
      bus.arith = ~ar;
      track($sformatf("rnd%0d", i), sh, ref_shift(a, sh, ar), 1'b0, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Iterative multi-cycle right shifter for the datapath's SRL/SRA operations.
- It is the counterpart to the fixed left-shift-by-2 used for address formation.
- It shifts a word right by a variable amount, one bit per cycle, filling with zeros (logical) or with the sign bit (arithmetic).
- It sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

Parameters:
- N, 32, data width in bits.
- SW, 5, shift-amount width; must equal $clog2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; sampled only while the unit is idle (busy=0).
- A  input  N  operand; captured on the accepting edge.
- shamt  input  SW  shift amount, 0..N-1; captured on the accepting edge.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on the accepting edge.
- B  output  N  result; valid while done=1; held until the next accepted start.
- busy  output  1  high while a shift is in progress.
- done  output  1  single-cycle pulse marking B valid.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, B=0, busy=0, done=0, internal count=0, latched fill bit=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: data_reg<=A, count<=shamt, fill<=arith & A[N-1].
  - Next state is DONE if shamt==0, else SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - Each edge: data_reg<={fill, data_reg[N-1:1]}, count<=count-1.
  - If count==1 at that edge, next state is DONE; otherwise remain in SHIFT.
  - start is ignored while in SHIFT, with no effect on the current operation.
- DONE:
  - done=1 for exactly this one cycle; B=data_reg.
  - The next edge returns to IDLE, unless start=1 at that edge. In that case the new request is accepted exactly as from IDLE (back-to-back operation); done drops for at least one cycle only if the new shamt is nonzero.
- Outputs:
  - busy=1 in SHIFT and 0 in IDLE/DONE; it is also 1 in the cycle after acceptance if shamt>0.
  - B always drives data_reg, but is valid only while done=1 and afterwards until the next acceptance.
  - B is not cleared on leaving DONE.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+shamt, i.e. shamt+1 cycles (min 1, max N).
- Fill rule: the sign bit is taken from A at capture time, not re-sampled. arith=1 with A[N-1]=0 behaves like logical.
- shamt==0: B=A unchanged after 1 cycle, for both modes.
- Reset asserted mid-operation: the operation is aborted immediately with no done pulse; all outputs return to reset values.
- Input changes on A/shamt/arith after acceptance do not affect the operation in progress.

Test Plan:
- Reset during idle and mid-SHIFT -> B=0, busy=0, done=0 immediately; no done pulse follows.
- A=0x80000000, shamt=4, arith=1 -> busy high for 4 cycles; done in cycle 5 after start with B=0xF8000000.
- Same A and shamt with arith=0 -> B=0x08000000 at done, same timing.
- A=0x12345678, shamt=0, either mode -> done the cycle after start, B=0x12345678, busy never asserted.
- A=0xFFFFFFFF, shamt=31, arith=0 -> done 32 cycles after start, B=0x00000001. Repeat with arith=1 -> B=0xFFFFFFFF.
- Handshake stress:
  - start re-pulsed with different operands mid-SHIFT -> ignored; the original result is produced.
  - start held high in the DONE cycle (A=0x00000100, shamt=8, arith=0) -> new operation accepted; done again 9 cycles later with B=0x00000001.
